rf_move_ctrl: RTL



---
 rtl/rf_move_ctrl_if.sv | 34 +++
 rtl/rf_move_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/rf_move_ctrl_if.sv
// Command, status and register-file BRAM port bundle for rf_move_ctrl.
// The master is the sequencer/RF side; the slave is the move controller.
interface rf_move_ctrl_if #(
  parameter int unsigned RF_DATA_W = 1408,
  parameter int unsigned RF_ADDR_W = 10,
  parameter int unsigned LEN_W     = 10
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [RF_ADDR_W-1:0] cmd_src;
  logic [RF_ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]     cmd_len;
  logic                 cmd_src_inc;
  logic                 cmd_dst_inc;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic [LEN_W-1:0]     done_count;
  logic [RF_ADDR_W-1:0] ram_addr;
  logic                 ram_re;
  logic                 ram_we;
  logic [RF_DATA_W-1:0] ram_data;
  logic [RF_DATA_W-1:0] ram_q;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_src_inc, cmd_dst_inc, abort, ram_q,
    input  cmd_ready, busy, done, done_count, ram_addr, ram_re, ram_we, ram_data
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_src_inc, cmd_dst_inc, abort, ram_q,
    output cmd_ready, busy, done, done_count, ram_addr, ram_re, ram_we, ram_data
  );
endinterface

// File: rtl/rf_move_ctrl.sv
// Register-file move controller: copies a run of RF words, one BRAM read then
// one write per word, between RAM and memory-mapped EU ports.
module rf_move_ctrl #(
  parameter int unsigned RF_DATA_W = 1408,
  parameter int unsigned RF_ADDR_W = 10,
  parameter int unsigned LEN_W     = 10
) (
  input logic           clk,
  input logic           rst_n,
  rf_move_ctrl_if.slave bus
);
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_RD   = 2'd1;
  localparam logic [ST_W-1:0] S_WR   = 2'd2;
  localparam logic [ST_W-1:0] S_DONE = 2'd3;

  logic [ST_W-1:0]      state, state_nxt;
  logic [RF_ADDR_W-1:0] src_reg, src_nxt;
  logic [RF_ADDR_W-1:0] dst_reg, dst_nxt;
  logic                 src_inc, src_inc_nxt;
  logic                 dst_inc, dst_inc_nxt;
  logic [LEN_W-1:0]     remain, remain_nxt;
  logic [LEN_W-1:0]     count, count_nxt;

  logic                 cmd_ready, cmd_ready_nxt;
  logic                 busy, busy_nxt;
  logic                 done, done_nxt;
  logic                 ram_re, ram_re_nxt;
  logic                 ram_we, ram_we_nxt;
  logic [RF_ADDR_W-1:0] ram_addr, ram_addr_nxt;
  logic [RF_DATA_W-1:0] wr_data;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt   = state;
    src_nxt     = src_reg;
    dst_nxt     = dst_reg;
    src_inc_nxt = src_inc;
    dst_inc_nxt = dst_inc;
    remain_nxt  = remain;
    count_nxt   = count;

    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          src_nxt     = bus.cmd_src;
          dst_nxt     = bus.cmd_dst;
          src_inc_nxt = bus.cmd_src_inc;
          dst_inc_nxt = bus.cmd_dst_inc;
          remain_nxt  = bus.cmd_len;
          count_nxt   = '0;
          state_nxt   = (bus.cmd_len != '0) ? S_RD : S_DONE;
        end
      end
      // An abort in RD drops the pending word without writing it.
      S_RD: state_nxt = bus.abort ? S_DONE : S_WR;
      S_WR: begin
        count_nxt  = count + LEN_W'(1);
        remain_nxt = remain - LEN_W'(1);
        src_nxt    = src_reg + RF_ADDR_W'(src_inc);
        dst_nxt    = dst_reg + RF_ADDR_W'(dst_inc);
        state_nxt  = (bus.abort || remain == LEN_W'(1)) ? S_DONE : S_RD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == S_IDLE);
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = (state_nxt == S_DONE);
    ram_re_nxt    = (state_nxt == S_RD);
    ram_we_nxt    = (state_nxt == S_WR);
    ram_addr_nxt  = '0;
    if (state_nxt == S_RD) begin
      ram_addr_nxt = src_nxt;
    end else if (state_nxt == S_WR) begin
      ram_addr_nxt = dst_nxt;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      src_inc   <= 1'b0;
      dst_inc   <= 1'b0;
      remain    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
    end else begin
      state     <= state_nxt;
      src_reg   <= src_nxt;
      dst_reg   <= dst_nxt;
      src_inc   <= src_inc_nxt;
      dst_inc   <= dst_inc_nxt;
      remain    <= remain_nxt;
      count     <= count_nxt;
      cmd_ready <= cmd_ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      ram_re    <= ram_re_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
    end
  end

  // Read data goes straight back out as write data; no capture register.
  assign wr_data        = bus.ram_q;
  assign bus.ram_data   = wr_data;
  assign bus.cmd_ready  = cmd_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.done_count = count;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_re     = ram_re;
  assign bus.ram_we     = ram_we;
endmodule
